// File: rtl/inst_fetch.sv
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch stage feeding instruction decode. Holds the
//               architectural fetch PC, keeps at most one instruction-memory
//               request outstanding, and parks each returned instruction with
//               its PC in a one-entry output buffer drained by decode through
//               a valid/ready handshake. A branch redirect flushes the buffer,
//               discards any in-flight fetch and restarts at the target.
// Ports       :
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   branch_valid   single-cycle redirect pulse from decode
//   branch_target  redirect PC (bits [1:0] ignored)
//   inst_req       memory request valid
//   inst_addr      word-aligned request address
//   inst_gnt       memory accepted the request this cycle
//   inst_rvalid    response valid (at least one cycle after the grant)
//   inst_rdata     response instruction word
//   if_valid       output buffer holds an instruction
//   if_pc          PC of the buffered instruction
//   if_inst        buffered instruction word
//   id_ready       decode accepts the buffer this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC = 32'h1c00_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_valid,
  input  logic [`ADDR_WIDTH-1:0] branch_target,
  output logic                   inst_req,
  output logic [`ADDR_WIDTH-1:0] inst_addr,
  input  logic                   inst_gnt,
  input  logic                   inst_rvalid,
  input  logic [`INST_WIDTH-1:0] inst_rdata,
  output logic                   if_valid,
  output logic [`ADDR_WIDTH-1:0] if_pc,
  output logic [`INST_WIDTH-1:0] if_inst,
  input  logic                   id_ready
);

  localparam logic [`ADDR_WIDTH-1:0] PC_STEP = 4;

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t                   state;
  state_t                   state_next;

  logic [`ADDR_WIDTH-1:0]   pc;        // next address to request
  logic [`ADDR_WIDTH-1:0]   fetch_pc;  // address of the outstanding request
  logic                     buf_valid;
  logic [`ADDR_WIDTH-1:0]   buf_pc;
  logic [`INST_WIDTH-1:0]   buf_inst;
  logic                     discard;   // outstanding response is wrong-path

  logic                     xfer;
  logic                     buf_free;
  logic                     grant;
  logic                     resp;
  logic                     load;
  logic [`ADDR_WIDTH-1:0]   target_aligned;

  // The low target bits are architecturally ignored.
  logic                     unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];

  assign target_aligned = {branch_target[`ADDR_WIDTH-1:2], 2'b00};

  assign xfer     = buf_valid && id_ready;
  // A request may be launched into a buffer that decode drains this very
  // cycle; the response cannot arrive before the following cycle.
  assign buf_free = !buf_valid || xfer;
  assign grant    = inst_req && inst_gnt;
  // Responses seen outside WAIT are protocol violations and are ignored.
  assign resp     = (state == ST_WAIT) && inst_rvalid;
  // A redirect coinciding with the response kills the response too.
  assign load     = resp && !discard && !branch_valid;

  assign inst_addr = pc;
  assign if_valid  = buf_valid;
  assign if_pc     = buf_pc;
  assign if_inst   = buf_inst;

  // --------------------------------------------------------------------------
  // FSM next-state and request generation
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    inst_req   = 1'b0;
    case (state)
      ST_REQ: begin
        // Redirect gates the request off so inst_addr never changes under a
        // pending, ungranted request.
        inst_req = buf_free && !branch_valid && !rst;
        if (inst_req && inst_gnt) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (inst_rvalid) begin
          state_next = ST_REQ;
        end
      end
      default: begin
        state_next = ST_REQ;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_REQ;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // PC, discard flag and output buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      fetch_pc  <= RESET_PC;
      discard   <= 1'b0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
    end else begin
      if (grant) begin
        fetch_pc <= pc;
      end

      // Redirect wins over the sequential increment; pc + 4 wraps naturally.
      if (branch_valid) begin
        pc <= target_aligned;
      end else if (load) begin
        pc <= fetch_pc + PC_STEP;
      end

      // Any response in WAIT retires the outstanding request, so the flag is
      // cleared even when a new redirect lands in the same cycle. A redirect
      // while already discarding leaves the flag set.
      if (resp) begin
        discard <= 1'b0;
      end else if (branch_valid && ((state == ST_WAIT) || grant)) begin
        discard <= 1'b1;
      end

      // The flush applies even if decode takes the entry in the same cycle;
      // decode resolves that ordering on its side.
      if (branch_valid) begin
        buf_valid <= 1'b0;
      end else if (load) begin
        buf_valid <= 1'b1;
        buf_pc    <= fetch_pc;
        buf_inst  <= inst_rdata;
      end else if (xfer) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none

// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch. A per-cycle vector table
//               covers reset, sequential fetch and a decode stall; directed
//               sequences cover redirects, PC wrap and reset during a fetch.
//               A scoreboard queues the expected {pc, inst} at every grant
//               and compares on every decode transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk;
  logic        rst;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;

  inst_fetch #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_gnt      (inst_gnt),
    .inst_rvalid   (inst_rvalid),
    .inst_rdata    (inst_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .id_ready      (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        rdy;
    int          lat;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  exp_t        sb[$];
  int          n_vec    = 0;
  int          n_err    = 0;
  int          n_grants = 0;
  int          n_xfers  = 0;
  logic [31:0] last_pc  = 32'h0;
  logic [31:0] exp_next = RST_PC;
  logic        pend     = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt = 0;
  int          mem_lat  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  function automatic vec_t mk(input logic r, input logic rdy, input int lat,
                              input logic chk, input logic req,
                              input logic [31:0] addr, input logic vld,
                              input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.lat = lat; v.chk = chk;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock cycle: inputs are already driven for this cycle. Observe what
  // the upcoming edge will do, advance, then update the memory model.
  task automatic tick();
    exp_t e;
    #1;
    if (!rst && if_valid && id_ready) begin
      n_xfers++;
      last_pc = if_pc;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_xfer: got pc %h, expected no transfer", if_pc);
      end else begin
        e = sb.pop_front();
        check("xfer_pc", if_pc, e.pc);
        check("xfer_inst", if_inst, e.inst);
      end
    end
    if (inst_req && inst_gnt) begin
      n_grants++;
      check("req_addr", inst_addr, exp_next);
      e.pc   = exp_next;
      e.inst = mem_word(exp_next);
      sb.push_back(e);
      exp_next  = exp_next + 32'd4;
      pend      = 1'b1;
      pend_addr = inst_addr;
      pend_cnt  = mem_lat;
    end
    if (branch_valid) begin
      check("req_gated", {31'b0, inst_req}, 32'd0);
      sb.delete();
      exp_next = {branch_target[31:2], 2'b00};
    end
    if (rst) begin
      sb.delete();
      exp_next = RST_PC;
    end
    @(posedge clk);
    @(negedge clk);
    inst_rvalid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        inst_rvalid = 1'b1;
        inst_rdata  = mem_word(pend_addr);
        pend        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
  endtask

  task automatic wait_grant(input int max);
    int start;
    start = n_grants;
    for (int k = 0; k < max && n_grants == start; k++) tick();
    if (n_grants == start) timeout("wait_grant");
  endtask

  task automatic wait_xfer(input int n, input int max);
    int start;
    start = n_xfers;
    for (int k = 0; k < max && n_xfers < start + n; k++) tick();
    if (n_xfers < start + n) timeout("wait_xfer");
  endtask

  task automatic wait_req(input int max);
    for (int k = 0; k < max; k++) begin
      #1;
      if (inst_req) break;
      tick();
    end
    if (!inst_req) timeout("wait_req");
  endtask

  task automatic wait_valid(input int max);
    for (int k = 0; k < max; k++) begin
      #1;
      if (if_valid) break;
      tick();
    end
    if (!if_valid) timeout("wait_valid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[14];
    // rst rdy lat chk req addr         vld pc
    vt[0]  = mk(1, 1, 0, 0, 0, 32'h0,        0, 32'h0);
    vt[1]  = mk(1, 1, 0, 1, 0, RST_PC,       0, 32'h0);
    vt[2]  = mk(0, 1, 0, 1, 1, 32'h1c000000, 0, 32'h0);
    vt[3]  = mk(0, 1, 0, 1, 0, 32'h0,        0, 32'h0);
    vt[4]  = mk(0, 1, 0, 1, 1, 32'h1c000004, 1, 32'h1c000000);
    vt[5]  = mk(0, 1, 0, 1, 0, 32'h0,        0, 32'h0);
    vt[6]  = mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h1c000004);
    vt[7]  = mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h1c000004);
    vt[8]  = mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h1c000004);
    vt[9]  = mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h1c000004);
    vt[10] = mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h1c000004);
    vt[11] = mk(0, 1, 0, 1, 1, 32'h1c000008, 1, 32'h1c000004);
    vt[12] = mk(0, 1, 0, 1, 0, 32'h0,        0, 32'h0);
    vt[13] = mk(0, 1, 2, 1, 1, 32'h1c00000c, 1, 32'h1c000008);

    rst           = 1'b1;
    branch_valid  = 1'b0;
    branch_target = 32'h0;
    inst_gnt      = 1'b1;
    inst_rvalid   = 1'b0;
    inst_rdata    = 32'h0;
    id_ready      = 1'b1;

    // Reset, sequential fetch, decode stall and release.
    for (int i = 0; i < 14; i++) begin
      rst      = vt[i].rst;
      id_ready = vt[i].rdy;
      mem_lat  = vt[i].lat;
      #1;
      if (vt[i].chk) begin
        check($sformatf("v%0d_req", i), {31'b0, inst_req}, {31'b0, vt[i].req});
        if (vt[i].req || vt[i].rst)
          check($sformatf("v%0d_addr", i), inst_addr, vt[i].addr);
        check($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, vt[i].vld});
        if (vt[i].vld) begin
          check($sformatf("v%0d_pc", i), if_pc, vt[i].pc);
          check($sformatf("v%0d_inst", i), if_inst, mem_word(vt[i].pc));
        end else if (vt[i].rst) begin
          check($sformatf("v%0d_pc", i), if_pc, 32'h0);
          check($sformatf("v%0d_inst", i), if_inst, 32'h0);
        end
      end
      tick();
    end

    // Redirect while waiting; the response arrives two cycles later.
    mem_lat       = 0;
    branch_valid  = 1'b1;
    branch_target = 32'h1c000103;
    #1;
    check("wait_no_req", {31'b0, inst_req}, 32'd0);
    tick();
    branch_valid = 1'b0;
    wait_req(10);
    check("redir_wait_addr", inst_addr, 32'h1c000100);
    wait_xfer(1, 20);
    check("redir_wait_pc", last_pc, 32'h1c000100);

    // Redirect with a held buffer entry.
    id_ready = 1'b0;
    wait_valid(20);
    branch_valid  = 1'b1;
    branch_target = 32'h1c000200;
    tick();
    branch_valid = 1'b0;
    #1;
    check("flush_valid", {31'b0, if_valid}, 32'd0);
    check("flush_req", {31'b0, inst_req}, 32'd1);
    check("flush_addr", inst_addr, 32'h1c000200);
    id_ready = 1'b1;
    wait_xfer(1, 20);
    check("flush_pc", last_pc, 32'h1c000200);

    // PC wrap.
    branch_valid  = 1'b1;
    branch_target = 32'hffff_fffc;
    tick();
    branch_valid = 1'b0;
    wait_xfer(2, 30);
    check("wrap_pc", last_pc, 32'h0000_0000);

    // Back-to-back redirects during a slow fetch.
    mem_lat = 3;
    wait_grant(20);
    branch_valid  = 1'b1;
    branch_target = 32'h1c000300;
    tick();
    branch_target = 32'h1c000400;
    tick();
    branch_valid = 1'b0;
    mem_lat      = 0;
    wait_xfer(1, 30);
    check("b2b_pc", last_pc, 32'h1c000400);

    // Reset during WAIT with a late response afterwards.
    mem_lat = 3;
    wait_grant(20);
    rst = 1'b1;
    tick();
    #1;
    check("mrst_valid", {31'b0, if_valid}, 32'd0);
    check("mrst_pc", if_pc, 32'h0);
    check("mrst_inst", if_inst, 32'h0);
    check("mrst_req", {31'b0, inst_req}, 32'd0);
    check("mrst_addr", inst_addr, RST_PC);
    tick();
    rst      = 1'b0;
    inst_gnt = 1'b0;
    #1;
    check("post_rst_req", {31'b0, inst_req}, 32'd1);
    check("post_rst_addr", inst_addr, RST_PC);
    tick();
    #1;
    check("late_rvalid_req", {31'b0, inst_req}, 32'd1);
    check("late_rvalid_addr", inst_addr, RST_PC);
    check("late_rvalid_valid", {31'b0, if_valid}, 32'd0);
    tick();
    inst_gnt = 1'b1;
    mem_lat  = 0;
    wait_xfer(1, 20);
    check("post_rst_pc", last_pc, RST_PC);
    for (int k = 0; k < 4; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
